// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants, exception codes and the per-edge action selector for the
// fetch->decode pipeline register.
package fd_pipe_reg_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          EXC_W_DEF     = 5;
    localparam logic [31:0] RESET_PC8_DEF = 32'h0000_3008;
    localparam int          ERET_OFS_DEF  = 8;
    localparam int          CNT_W_DEF     = 16;

    localparam logic [EXC_W_DEF-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_ERET  = 2'd2,
        ACT_FLUSH = 2'd3
    } fd_action_e;

    // Fixed priority: flush > iseret > stall > load.
    function automatic fd_action_e fd_select(input logic flush,
                                             input logic iseret,
                                             input logic stall);
        if (flush)       return ACT_FLUSH;
        else if (iseret) return ACT_ERET;
        else if (stall)  return ACT_STALL;
        else             return ACT_LOAD;
    endfunction

endpackage

// File: rtl/fd_pipe_reg_if.sv
// Fetch/control side <-> D-stage register bundle. master drives the F-stage
// fields and control, slave is the pipeline register itself.
interface fd_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              iseret;
    logic              stall;
    logic              valid_i;
    logic [DATA_W-1:0] instr_i;
    logic [DATA_W-1:0] pc8_i;
    logic [DATA_W-1:0] npcout;
    logic              bd_i;
    logic [EXC_W-1:0]  exccode_i;
    logic              cnt_clr;

    logic              valid_d;
    logic [DATA_W-1:0] instr_d;
    logic [DATA_W-1:0] pc8_d;
    logic              bd_d;
    logic [EXC_W-1:0]  exccode_d;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output flush, iseret, stall, valid_i, instr_i, pc8_i, npcout,
               bd_i, exccode_i, cnt_clr,
        input  valid_d, instr_d, pc8_d, bd_d, exccode_d, stall_cnt, bubble_cnt
    );

    modport slave (
        input  flush, iseret, stall, valid_i, instr_i, pc8_i, npcout,
               bd_i, exccode_i, cnt_clr,
        output valid_d, instr_d, pc8_d, bd_d, exccode_d, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/fd_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear that overrides the increment.
module fd_pipe_reg_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch->decode pipeline register with flush / ERET redirect / stall priority
// and saturating stall and bubble performance counters.
module fd_pipe_reg
    import fd_pipe_reg_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                EXC_W     = EXC_W_DEF,
    parameter logic [DATA_W-1:0] RESET_PC8 = DATA_W'(RESET_PC8_DEF),
    parameter int                ERET_OFS  = ERET_OFS_DEF,
    parameter int                CNT_W     = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         clr,
    fd_pipe_reg_if.slave bus
);

    fd_action_e        w_action;
    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc8;
    logic              r_bd;
    logic [EXC_W-1:0]  r_exc;

    assign w_action = fd_select(bus.flush, bus.iseret, bus.stall);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc8   <= RESET_PC8;
            r_bd    <= 1'b0;
            r_exc   <= '0;
        end else begin
            unique case (w_action)
                ACT_FLUSH: begin
                    r_valid <= 1'b0;
                    r_instr <= '0;
                    r_pc8   <= RESET_PC8;
                    r_bd    <= 1'b0;
                    r_exc   <= '0;
                end
                ACT_ERET: begin
                    r_valid <= 1'b0;
                    r_instr <= '0;
                    r_pc8   <= bus.npcout + DATA_W'(ERET_OFS);
                    r_bd    <= 1'b0;
                    r_exc   <= '0;
                end
                ACT_STALL: begin
                end
                ACT_LOAD: begin
                    // An invalid fetch still carries its PC and delay-slot flag.
                    r_valid <= bus.valid_i;
                    r_instr <= bus.valid_i ? bus.instr_i : '0;
                    r_pc8   <= bus.pc8_i;
                    r_bd    <= bus.bd_i;
                    r_exc   <= bus.valid_i ? bus.exccode_i : '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.valid_d   = r_valid;
    assign bus.instr_d   = r_instr;
    assign bus.pc8_d     = r_pc8;
    assign bus.bd_d      = r_bd;
    assign bus.exccode_d = r_exc;

    // Index 0 counts stall edges, index 1 counts inserted bubbles.
    logic [1:0]       w_inc;
    logic [CNT_W-1:0] w_cnt [2];

    assign w_inc[0] = (w_action == ACT_STALL);
    assign w_inc[1] = (w_action == ACT_FLUSH) || (w_action == ACT_ERET) ||
                      ((w_action == ACT_LOAD) && !bus.valid_i);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            fd_pipe_reg_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (clr),
                .i_inc (w_inc[gi]),
                .i_clr (bus.cnt_clr),
                .o_cnt (w_cnt[gi])
            );
        end
    endgenerate

    assign bus.stall_cnt  = w_cnt[0];
    assign bus.bubble_cnt = w_cnt[1];

endmodule
